// File: rtl/clint_timer_master.sv
// clint_timer_master
//   Bus initiator that performs high-level timer/IPI commands on a CLINT
//   slave port: coherent 64-bit mtime read, arm/disarm of a hart's
//   mtimecmp relative to the current time, and msip set/clear.
//
// Ports
//   clk, reset               clock, asynchronous active-low reset
//   cmd_valid/cmd_ready      command handshake (one command at a time)
//   cmd_op/cmd_hart/cmd_arg  0 READ_TIME, 1 ARM(delta), 2 DISARM, 3 SET_IPI(bit0)
//   rsp_valid/rsp_err/rsp_time  one-cycle completion pulse with result
//   m_valid/m_address/m_wdata/m_wstrb  bus request (wstrb 0 = read)
//   m_rdata/m_ready          bus response
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for a command, cmd_ready high
// ISSUE  | bus request held until the slave answers
// DRAIN  | request dropped, waiting for the slave's ready to fall
// DONE   | one-cycle response pulse
module clint_timer_master #(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter int                N_CORES    = 1,
  parameter logic [ADDR_W-1:0] CLINT_BASE = 'h0200_0000,
  parameter int                TIMEOUT    = 255,
  parameter int                MAX_RETRY  = 3,
  localparam int               HART_W     = (N_CORES > 1) ? $clog2(N_CORES) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [HART_W-1:0]   cmd_hart,
  input  logic [63:0]         cmd_arg,
  output logic                rsp_valid,
  output logic                rsp_err,
  output logic [63:0]         rsp_time,
  output logic                m_valid,
  output logic [ADDR_W-1:0]   m_address,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_ready
);

  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);

  localparam logic [1:0] OP_READ   = 2'd0;
  localparam logic [1:0] OP_ARM    = 2'd1;
  localparam logic [1:0] OP_DISARM = 2'd2;
  localparam logic [1:0] OP_IPI    = 2'd3;

  localparam logic [31:0] OFF_MTIME_LO = 32'h0000_BFF8;
  localparam logic [31:0] OFF_MTIME_HI = 32'h0000_BFFC;
  localparam logic [31:0] OFF_MTIMECMP = 32'h0000_4000;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN, ST_DONE} state_t;

  typedef enum logic [2:0] {
    SP_RD_HI1, SP_RD_LO, SP_RD_HI2,
    SP_WR_HI_MAX, SP_WR_LO, SP_WR_HI,
    SP_WR_LO_MAX, SP_WR_MSIP
  } step_t;

  state_t            state_q, state_nxt;
  step_t             step_q;
  logic [1:0]        op_q;
  logic [HART_W-1:0] hart_q;
  logic [63:0]       arg_q;
  logic [31:0]       h1_q, h2_q, lo_q;
  logic [63:0]       res_q;
  logic              err_q;
  logic [TMR_W-1:0]  tmr_q;
  logic [RTY_W-1:0]  retry_q;

  logic        hart_bad, tmr_zero, hi_match, retry_done, last_step, is_write;
  logic [31:0] offset, wdata, cmp_off, msip_off;

  assign hart_bad   = (32'(cmd_hart) >= 32'(N_CORES));
  assign tmr_zero   = (tmr_q == '0);
  assign hi_match   = (h2_q == h1_q);
  assign retry_done = (retry_q == RTY_W'(MAX_RETRY));
  assign cmp_off    = OFF_MTIMECMP + (32'(hart_q) << 3);
  assign msip_off   = 32'(hart_q) << 2;

  // Whether leaving DRAIN ends the command (no further bus step).
  always_comb begin
    last_step = 1'b0;
    case (step_q)
      SP_RD_HI2:                         last_step = hi_match ? (op_q != OP_ARM) : retry_done;
      SP_WR_HI, SP_WR_LO_MAX, SP_WR_MSIP: last_step = 1'b1;
      default:                           last_step = 1'b0;
    endcase
  end

  // Bus step decode.
  always_comb begin
    offset   = 32'h0;
    wdata    = 32'h0;
    is_write = 1'b1;
    case (step_q)
      SP_RD_HI1, SP_RD_HI2: begin offset = OFF_MTIME_HI; is_write = 1'b0; end
      SP_RD_LO:             begin offset = OFF_MTIME_LO; is_write = 1'b0; end
      SP_WR_HI_MAX:         begin offset = cmp_off + 32'd4; wdata = 32'hFFFF_FFFF; end
      SP_WR_LO:             begin offset = cmp_off;         wdata = res_q[31:0]; end
      SP_WR_HI:             begin offset = cmp_off + 32'd4; wdata = res_q[63:32]; end
      SP_WR_LO_MAX:         begin offset = cmp_off;         wdata = 32'hFFFF_FFFF; end
      SP_WR_MSIP:           begin offset = msip_off;        wdata = {31'b0, arg_q[0]}; end
      default:              begin offset = 32'h0; wdata = 32'h0; end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_nxt;
  end

  // Next state
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE:  if (cmd_valid) state_nxt = hart_bad ? ST_DONE : ST_ISSUE;
      ST_ISSUE: if (m_ready) state_nxt = ST_DRAIN;
                else if (tmr_zero) state_nxt = ST_DONE;
      ST_DRAIN: if (!m_ready) state_nxt = last_step ? ST_DONE : ST_ISSUE;
                else if (tmr_zero) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_time  = 64'h0;
    m_valid   = 1'b0;
    m_address = '0;
    m_wdata   = '0;
    m_wstrb   = '0;
    case (state_q)
      ST_IDLE:  cmd_ready = 1'b1;
      ST_ISSUE: begin
        m_valid   = 1'b1;
        m_address = CLINT_BASE + ADDR_W'(offset);
        if (is_write) begin
          m_wdata = DATA_W'(wdata);
          m_wstrb = '1;
        end
      end
      ST_DONE: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        rsp_time  = res_q;
      end
      default: ;
    endcase
  end

  // Command datapath: step sequencing, captured read data, phase timer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step_q  <= SP_RD_HI1;
      op_q    <= OP_READ;
      hart_q  <= '0;
      arg_q   <= 64'h0;
      h1_q    <= 32'h0;
      h2_q    <= 32'h0;
      lo_q    <= 32'h0;
      res_q   <= 64'h0;
      err_q   <= 1'b0;
      tmr_q   <= TMR_LOAD;
      retry_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (cmd_valid) begin
          op_q    <= cmd_op;
          hart_q  <= cmd_hart;
          arg_q   <= cmd_arg;
          res_q   <= 64'h0;
          err_q   <= hart_bad;
          retry_q <= '0;
          tmr_q   <= TMR_LOAD;
          case (cmd_op)
            OP_DISARM: step_q <= SP_WR_HI_MAX;
            OP_IPI:    step_q <= SP_WR_MSIP;
            default:   step_q <= SP_RD_HI1;
          endcase
        end
        ST_ISSUE: begin
          if (m_ready) begin
            tmr_q <= TMR_LOAD;
            case (step_q)
              SP_RD_HI1: h1_q <= m_rdata[31:0];
              SP_RD_LO:  lo_q <= m_rdata[31:0];
              SP_RD_HI2: h2_q <= m_rdata[31:0];
              default: ;
            endcase
          end else if (tmr_zero) begin
            err_q <= 1'b1;
            res_q <= 64'h0;
          end else begin
            tmr_q <= tmr_q - 1'b1;
          end
        end
        ST_DRAIN: begin
          if (!m_ready) begin
            tmr_q <= TMR_LOAD;
            case (step_q)
              SP_RD_HI1: step_q <= SP_RD_LO;
              SP_RD_LO:  step_q <= SP_RD_HI2;
              SP_RD_HI2: begin
                if (hi_match) begin
                  if (op_q == OP_ARM) begin
                    step_q <= SP_WR_HI_MAX;
                    res_q  <= {h1_q, lo_q} + arg_q;
                  end else begin
                    res_q <= {h1_q, lo_q};
                  end
                end else if (retry_done) begin
                  err_q <= 1'b1;
                  res_q <= 64'h0;
                end else begin
                  // mtime carried into hi between reads: redo lo/hi pair
                  retry_q <= retry_q + 1'b1;
                  h1_q    <= h2_q;
                  step_q  <= SP_RD_LO;
                end
              end
              SP_WR_HI_MAX: step_q <= (op_q == OP_ARM) ? SP_WR_LO : SP_WR_LO_MAX;
              SP_WR_LO:     step_q <= SP_WR_HI;
              SP_WR_LO_MAX: res_q  <= 64'hFFFF_FFFF_FFFF_FFFF;
              default: ;
            endcase
          end else if (tmr_zero) begin
            err_q <= 1'b1;
            res_q <= 64'h0;
          end else begin
            tmr_q <= tmr_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_clint_timer_master.sv
module tb_clint_timer_master;

  localparam int N_CORES   = 3;
  localparam int TIMEOUT   = 16;
  localparam int MAX_RETRY = 3;
  localparam logic [31:0] BASE = 32'h0200_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [1:0]  cmd_hart = 2'd0;
  logic [63:0] cmd_arg = 64'h0;
  logic        rsp_valid, rsp_err;
  logic [63:0] rsp_time;
  logic        m_valid;
  logic [31:0] m_address, m_wdata;
  logic [3:0]  m_wstrb;
  logic [31:0] m_rdata;
  logic        m_ready;

  clint_timer_master #(
    .ADDR_W(32), .DATA_W(32), .N_CORES(N_CORES), .CLINT_BASE(BASE),
    .TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_hart(cmd_hart), .cmd_arg(cmd_arg),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_time(rsp_time),
    .m_valid(m_valid), .m_address(m_address), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_rdata(m_rdata), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  // ---------------- CLINT slave model ----------------
  // mode 0: mtime held at mt; mode 1: hi reads 1 then 2; mode 2: hi changes every read
  int          mode = 0;
  logic [63:0] mt = 64'h0;
  int          lag = 2;
  int          stretch = 0;
  bit          never_rdy = 1'b0;
  bit          clr_log = 1'b0;
  int          vcnt = 0, scnt = 0, n_tx = 0, hi_reads = 0, viol = 0, rsp_cnt = 0;
  logic        mv_prev = 1'b0;
  logic [31:0] log_a [16];
  logic [31:0] log_w [16];
  logic [3:0]  log_s [16];

  always_comb begin
    m_rdata = 32'h0;
    if (m_address == BASE + 32'hBFFC) begin
      case (mode)
        0:       m_rdata = mt[63:32];
        1:       m_rdata = (hi_reads == 0) ? 32'd1 : 32'd2;
        default: m_rdata = 32'(hi_reads);
      endcase
    end else if (m_address == BASE + 32'hBFF8) begin
      m_rdata = mt[31:0];
    end
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_ready <= 1'b0;
      vcnt    <= 0;
      scnt    <= 0;
      mv_prev <= 1'b0;
    end else begin
      mv_prev <= m_valid;
      if (m_valid && m_ready && !mv_prev) viol <= viol + 1;
      if (m_valid && m_ready) begin
        if (n_tx < 16) begin
          log_a[n_tx[3:0]] <= m_address;
          log_w[n_tx[3:0]] <= m_wdata;
          log_s[n_tx[3:0]] <= m_wstrb;
        end
        n_tx <= n_tx + 1;
        if (m_wstrb == 4'h0 && m_address == BASE + 32'hBFFC) hi_reads <= hi_reads + 1;
        vcnt    <= 0;
        scnt    <= stretch;
        m_ready <= (stretch > 0);
      end else if (m_valid) begin
        vcnt <= vcnt + 1;
        if (!never_rdy && vcnt + 1 >= lag) m_ready <= 1'b1;
      end else if (m_ready) begin
        if (scnt <= 1) m_ready <= 1'b0;
        else           scnt <= scnt - 1;
      end
      if (clr_log) begin
        n_tx     <= 0;
        hi_reads <= 0;
      end
    end
  end

  always @(posedge clk) if (rsp_valid) rsp_cnt <= rsp_cnt + 1;

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]       op;
    logic [1:0]       hart;
    logic [63:0]      arg;
    int               mode;
    logic [63:0]      mt;
    int               stretch;
    logic             err;
    logic [63:0]      tm;
    int               ntx;
    logic [2:0][31:0] a;   // offsets of the last (up to 3) transactions
    logic [2:0][31:0] w;
    logic [2:0][3:0]  s;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] op, input logic [1:0] hart, input logic [63:0] arg,
                              input int md, input logic [63:0] m, input int st,
                              input logic err, input logic [63:0] tm, input int ntx,
                              input logic [31:0] a0, input logic [31:0] w0, input logic [3:0] s0,
                              input logic [31:0] a1, input logic [31:0] w1, input logic [3:0] s1,
                              input logic [31:0] a2, input logic [31:0] w2, input logic [3:0] s2);
    vec_t v;
    v.op = op; v.hart = hart; v.arg = arg; v.mode = md; v.mt = m; v.stretch = st;
    v.err = err; v.tm = tm; v.ntx = ntx;
    v.a[0] = a0; v.w[0] = w0; v.s[0] = s0;
    v.a[1] = a1; v.w[1] = w1; v.s[1] = s1;
    v.a[2] = a2; v.w[2] = w2; v.s[2] = s2;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    int cyc;
    int m;
    int idx;
    mode = v.mode; mt = v.mt; stretch = v.stretch; never_rdy = 1'b0;
    clr_log = 1'b1;
    @(negedge clk);
    clr_log = 1'b0;
    cmd_op = v.op; cmd_hart = v.hart; cmd_arg = v.arg; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk({tag, ".cmd_ready_busy"}, 64'(cmd_ready), 64'h0);
    cyc = 0;
    while (!rsp_valid && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    if (!rsp_valid) begin
      n_cmp++; n_bad++;
      $display("FAIL %s.rsp_timeout: got no rsp_valid expected rsp_valid within 3000 cycles", tag);
    end else begin
      chk({tag, ".rsp_err"}, 64'(rsp_err), 64'(v.err));
      chk({tag, ".rsp_time"}, rsp_time, v.tm);
    end
    @(negedge clk);
    chk({tag, ".rsp_pulse"}, 64'(rsp_valid), 64'h0);
    chk({tag, ".cmd_ready_back"}, 64'(cmd_ready), 64'h1);
    chk({tag, ".n_tx"}, 64'(n_tx), 64'(v.ntx));
    m = (v.ntx < 3) ? v.ntx : 3;
    for (int k = 0; k < m; k++) begin
      idx = n_tx - m + k;
      if (idx < 0) idx = 0;
      if (idx > 15) idx = 15;
      chk($sformatf("%s.addr%0d", tag, k), 64'(log_a[idx[3:0]]), 64'(BASE + v.a[k]));
      chk($sformatf("%s.wdata%0d", tag, k), 64'(log_w[idx[3:0]]), 64'(v.w[k]));
      chk($sformatf("%s.wstrb%0d", tag, k), 64'(log_s[idx[3:0]]), 64'(v.s[k]));
    end
  endtask

  localparam logic [31:0] FF = 32'hFFFF_FFFF;

  vec_t vecs [10];
  int   cnt, cyc, base_rsp;

  initial begin
    vecs[0] = mk(2'd0, 2'd0, 64'h0, 0, 64'h0000_0001_FFFF_FF00, 0, 1'b0, 64'h0000_0001_FFFF_FF00, 3,
                 32'hBFFC, 0, 4'h0, 32'hBFF8, 0, 4'h0, 32'hBFFC, 0, 4'h0);
    vecs[1] = mk(2'd0, 2'd0, 64'h0, 1, 64'h0000_0000_1234_5678, 0, 1'b0, 64'h0000_0002_1234_5678, 5,
                 32'hBFFC, 0, 4'h0, 32'hBFF8, 0, 4'h0, 32'hBFFC, 0, 4'h0);
    vecs[2] = mk(2'd0, 2'd0, 64'h0, 2, 64'h0, 0, 1'b1, 64'h0, 3 + 2 * MAX_RETRY,
                 32'hBFFC, 0, 4'h0, 32'hBFF8, 0, 4'h0, 32'hBFFC, 0, 4'h0);
    vecs[3] = mk(2'd1, 2'd0, 64'h10, 0, 64'hFFFF_FFFF_FFFF_FFF8, 0, 1'b0, 64'h8, 6,
                 32'h4004, FF, 4'hF, 32'h4000, 32'h8, 4'hF, 32'h4004, 32'h0, 4'hF);
    vecs[4] = mk(2'd2, 2'd2, 64'h0, 0, 64'h0, 3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 2,
                 32'h4014, FF, 4'hF, 32'h4010, FF, 4'hF, 0, 0, 4'h0);
    vecs[5] = mk(2'd3, 2'd1, 64'h1, 0, 64'h0, 3, 1'b0, 64'h0, 1,
                 32'h0004, 32'h1, 4'hF, 0, 0, 4'h0, 0, 0, 4'h0);
    vecs[6] = mk(2'd3, 2'd0, 64'h2, 0, 64'h0, 0, 1'b0, 64'h0, 1,
                 32'h0000, 32'h0, 4'hF, 0, 0, 4'h0, 0, 0, 4'h0);
    vecs[7] = mk(2'd1, 2'd3, 64'h10, 0, 64'h5, 0, 1'b1, 64'h0, 0,
                 0, 0, 4'h0, 0, 0, 4'h0, 0, 0, 4'h0);
    vecs[8] = mk(2'd1, 2'd1, 64'h1_0000_0000, 0, 64'h5_0000_0010, 1, 1'b0, 64'h6_0000_0010, 6,
                 32'h400C, FF, 4'hF, 32'h4008, 32'h10, 4'hF, 32'h400C, 32'h6, 4'hF);
    vecs[9] = mk(2'd1, 2'd0, 64'h10, 2, 64'h0, 0, 1'b1, 64'h0, 3 + 2 * MAX_RETRY,
                 32'hBFFC, 0, 4'h0, 32'hBFF8, 0, 4'h0, 32'hBFFC, 0, 4'h0);

    #1 reset = 1'b0;
    #2;
    chk("reset.cmd_ready", 64'(cmd_ready), 64'h1);
    chk("reset.m_valid", 64'(m_valid), 64'h0);
    chk("reset.rsp_valid", 64'(rsp_valid), 64'h0);
    chk("reset.m_wstrb", 64'(m_wstrb), 64'h0);
    chk("reset.rsp_time", rsp_time, 64'h0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Slave never answers: abort after TIMEOUT cycles of m_valid
    never_rdy = 1'b1; mode = 0;
    cmd_op = 2'd0; cmd_hart = 2'd0; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    cnt = 0; cyc = 0;
    while (!rsp_valid && cyc < 500) begin
      if (m_valid) cnt++;
      @(negedge clk);
      cyc++;
    end
    chk("tmo.valid_cycles", 64'(cnt), 64'(TIMEOUT));
    chk("tmo.rsp_valid", 64'(rsp_valid), 64'h1);
    chk("tmo.rsp_err", 64'(rsp_err), 64'h1);
    chk("tmo.rsp_time", rsp_time, 64'h0);
    chk("tmo.m_valid", 64'(m_valid), 64'h0);
    @(negedge clk);
    chk("tmo.cmd_ready", 64'(cmd_ready), 64'h1);
    never_rdy = 1'b0;

    // Reset in the middle of an ARM while the request is on the bus
    mode = 0; mt = 64'h0000_0000_0000_0100; stretch = 0;
    repeat (2) @(negedge clk);
    base_rsp = rsp_cnt;
    cmd_op = 2'd1; cmd_hart = 2'd0; cmd_arg = 64'h5; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("rst.m_valid_before", 64'(m_valid), 64'h1);
    #2 reset = 1'b0;
    #1;
    chk("rst.m_valid_now", 64'(m_valid), 64'h0);
    chk("rst.cmd_ready_now", 64'(cmd_ready), 64'h1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    chk("rst.no_rsp", 64'(rsp_cnt), 64'(base_rsp));
    run_vec(mk(2'd2, 2'd0, 64'h0, 0, 64'h0, 0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 2,
               32'h4004, FF, 4'hF, 32'h4000, FF, 4'hF, 0, 0, 4'h0), "rst_disarm");

    chk("drain.req_while_ready", 64'(viol), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
